// File: rtl/cmd_seq_pkg.sv
// Shared state type, command byte constants and script entry layout for cmd_seq_player.
package cmd_seq_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_DONE, GAP} state_t;

   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] CMD_STOP = 8'h53;

   // Default-width entry; the player rebuilds the same {cmd, dly} layout from its own parameters.
   typedef struct packed {
      logic [7:0]  cmd;
      logic [15:0] dly;
   } entry_t;

endpackage

// File: rtl/cmd_seq_mem.sv
// Script register file: DEPTH entries, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; entries are undefined until written.
module cmd_seq_mem #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 24
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en && (int'(wr_addr) < DEPTH))
         mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cmd_seq_player.sv
// Plays a programmed script of command bytes into UART_tx over trmt/tx_done with per-entry gaps.
// Optional tx_done watchdog is built only when CMD_SEQ_TIMEOUT_EN is defined.
module cmd_seq_player
   import cmd_seq_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int DATA_W      = 8,
   parameter int DLY_W       = 16,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]          wr_cmd,
   input  logic [DLY_W-1:0]           wr_dly,
   input  logic [$clog2(DEPTH+1)-1:0] num_cmds,
   input  logic                       loop_mode,
   input  logic                       start,
   input  logic                       abort,
   output logic                       trmt,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_done,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH)-1:0]   cur_idx,
   output logic                       err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [DATA_W-1:0] cmd;
      logic [DLY_W-1:0]  dly;
   } ent_t;

   state_t           state;
   ent_t             wr_ent;
   ent_t             rd_ent;
   logic [CNT_W-1:0] num_lat;
   logic [CNT_W-1:0] num_clamped;
   logic             loop_lat;
   logic [DLY_W-1:0] gap_cnt;
   logic             last_entry;
   logic             wd_expired;

   assign wr_ent      = {wr_cmd, wr_dly};
   assign num_clamped = (int'(num_cmds) > DEPTH) ? CNT_W'(DEPTH) : num_cmds;
   assign last_entry  = ((CNT_W'(cur_idx) + CNT_W'(1)) == num_lat);
   assign busy        = (state != IDLE);

   cmd_seq_mem #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W + DLY_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_ent),
      .rd_addr (cur_idx),
      .rd_data (rd_ent)
   );

   // The gap length stays in gap_cnt from LOAD until tx_done, so it also picks GAP versus LOAD.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         trmt     <= 1'b0;
         tx_data  <= '0;
         done     <= 1'b0;
         cur_idx  <= '0;
         num_lat  <= '0;
         loop_lat <= 1'b0;
         gap_cnt  <= '0;
      end else begin
         trmt <= 1'b0;
         done <= 1'b0;
         if (abort) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     num_lat  <= num_clamped;
                     loop_lat <= loop_mode;
                     cur_idx  <= '0;
                     if (num_clamped == '0)
                        done <= 1'b1;
                     else
                        state <= LOAD;
                  end
               end
               LOAD: begin
                  tx_data <= rd_ent.cmd;
                  gap_cnt <= rd_ent.dly;
                  trmt    <= 1'b1;
                  state   <= SEND;
               end
               SEND: begin
                  state <= WAIT_DONE;
               end
               WAIT_DONE: begin
                  if (tx_done) begin
                     if (last_entry && !loop_lat) begin
                        done  <= 1'b1;
                        state <= IDLE;
                     end else begin
                        cur_idx <= last_entry ? '0 : cur_idx + IDX_W'(1);
                        state   <= (gap_cnt == '0) ? LOAD : GAP;
                     end
                  end else if (wd_expired) begin
                     state <= IDLE;
                  end
               end
               GAP: begin
                  gap_cnt <= gap_cnt - DLY_W'(1);
                  if (gap_cnt <= DLY_W'(1))
                     state <= LOAD;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef CMD_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            err_r;

   assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
   assign err        = err_r;

   // Watchdog counts cycles spent in WAIT_DONE; err stays set until the next accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         err_r  <= 1'b0;
      end else begin
         if (state != WAIT_DONE)
            wd_cnt <= '0;
         else if (!tx_done)
            wd_cnt <= wd_cnt + WD_W'(1);
         if (!abort) begin
            if (state == IDLE && start)
               err_r <= 1'b0;
            else if (state == WAIT_DONE && !tx_done && wd_expired)
               err_r <= 1'b1;
         end
      end
   end
`else
   assign wd_expired = 1'b0;
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_seq_player.sv
// Randomized self-checking bench for cmd_seq_player; expected trmt/done/busy timing is derived
// from an event timeline model (start, tx_done and gap lengths) kept inside the bench.
module tb_cmd_seq_player;
   import cmd_seq_pkg::*;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 8;
   localparam int DLY_W  = 16;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_addr;
   logic [DATA_W-1:0] wr_cmd;
   logic [DLY_W-1:0]  wr_dly;
   logic [CNT_W-1:0]  num_cmds;
   logic              loop_mode;
   logic              start;
   logic              abort;
   logic              trmt;
   logic [DATA_W-1:0] tx_data;
   logic              tx_done;
   logic              busy;
   logic              done;
   logic [IDX_W-1:0]  cur_idx;
   logic              err;

   int checks = 0;
   int passes = 0;
   int n      = 0;
   logic [DATA_W-1:0] scr_cmd [DEPTH];
   int                scr_dly [DEPTH];

   cmd_seq_player #(
      .DEPTH       (DEPTH),
      .DATA_W      (DATA_W),
      .DLY_W       (DLY_W),
      .TIMEOUT_CYC (50)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_cmd    (wr_cmd),
      .wr_dly    (wr_dly),
      .num_cmds  (num_cmds),
      .loop_mode (loop_mode),
      .start     (start),
      .abort     (abort),
      .trmt      (trmt),
      .tx_data   (tx_data),
      .tx_done   (tx_done),
      .busy      (busy),
      .done      (done),
      .cur_idx   (cur_idx),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected)
         passes++;
      else
         $display("[TB] FAIL %s at step %0d: got %0h, expected %0h", tag, n, actual, expected);
   endtask

   // One step: clock edge, then settle to the falling edge where outputs are sampled and inputs change.
   task automatic tick();
      @(posedge clk);
      n++;
      @(negedge clk);
   endtask

   task automatic writeEntry(input int idx, input logic [DATA_W-1:0] cmd, input int dly);
      entry_t e;
      e.cmd   = cmd;
      e.dly   = DLY_W'(dly);
      wr_en   = 1'b1;
      wr_addr = IDX_W'(idx);
      wr_cmd  = e.cmd;
      wr_dly  = e.dly;
      tick();
      wr_en = 1'b0;
      scr_cmd[idx] = e.cmd;
      scr_dly[idx] = int'(e.dly);
   endtask

   task automatic randomScript();
      for (int i = 0; i < DEPTH; i++) begin
         case ($urandom_range(0, 3))
            0:       writeEntry(i, CMD_GO, 0);
            1:       writeEntry(i, CMD_STOP, int'($urandom_range(0, 4)));
            default: writeEntry(i, DATA_W'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0);
         endcase
      end
   endtask

   // Timeline model: first byte 2 steps after start; each tx_done at step t schedules the next
   // byte at t+2+gap, or done at t+1 after the last one-shot byte; abort at a ends busy at a+1.
   task automatic applyStimulus(input int num, input bit loop_m, input int abort_after, input bit poke);
      int eff, pos, bytes, exp_trmt, exp_done, end_n, tx_at, last_trmt, start_n, budget;
      bit aborted, finished;
      eff       = (num > DEPTH) ? DEPTH : num;
      pos       = 0;
      bytes     = 0;
      tx_at     = -1;
      last_trmt = -10;
      aborted   = 1'b0;
      finished  = 1'b0;
      start_n   = n;
      exp_trmt  = (eff == 0) ? -1 : start_n + 2;
      exp_done  = (eff == 0) ? start_n + 1 : -1;
      end_n     = (eff == 0) ? start_n + 1 : -1;
      num_cmds  = CNT_W'(num);
      loop_mode = loop_m;
      start     = 1'b1;
      budget    = 4000;
      while (!finished && budget > 0) begin
         tick();
         budget--;
         checkOutput("trmt", 32'(trmt), 32'(n == exp_trmt));
         if (n == exp_trmt) begin
            checkOutput("tx_data", 32'(tx_data), 32'(scr_cmd[pos]));
            checkOutput("cur_idx", 32'(cur_idx), 32'(pos));
            tx_at     = n + int'($urandom_range(1, 6));
            last_trmt = n;
            bytes++;
         end
         checkOutput("done", 32'(done), 32'(n == exp_done));
         checkOutput("busy", 32'(busy), 32'(n > start_n && (end_n < 0 || n < end_n)));
         checkOutput("err", 32'(err), 32'(0));
         start   = 1'b0;
         abort   = 1'b0;
         tx_done = 1'b0;
         if (n == start_n + 1)
            num_cmds = CNT_W'($urandom_range(0, 15));
         if (poke && eff > 0 && n == start_n + 2) begin
            start     = 1'b1;
            num_cmds  = CNT_W'($urandom_range(0, 15));
            loop_mode = ~loop_m;
         end
         if (!aborted && abort_after > 0 && bytes == abort_after && n == last_trmt + 1) begin
            abort    = 1'b1;
            aborted  = 1'b1;
            exp_trmt = -1;
            exp_done = -1;
            end_n    = n + 1;
         end
         if (n == tx_at) begin
            tx_done = 1'b1;
            if (!aborted) begin
               if (pos == eff - 1 && !loop_m) begin
                  exp_done = n + 1;
                  end_n    = n + 1;
               end else begin
                  exp_trmt = n + 2 + scr_dly[pos];
                  pos      = (pos == eff - 1) ? 0 : pos + 1;
               end
            end
         end
         if (end_n >= 0 && n >= end_n + (aborted ? 15 : 3))
            finished = 1'b1;
      end
      checkOutput("run_ended", 32'(finished), 32'(1));
      start   = 1'b0;
      abort   = 1'b0;
      tx_done = 1'b0;
   endtask

   initial begin
      int num, abort_after;
      bit lp;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_cmd = '0; wr_dly = '0;
      num_cmds = '0; loop_mode = 1'b0; start = 1'b0; abort = 1'b0; tx_done = 1'b0;
      repeat (3) tick();
      checkOutput("rst_trmt", 32'(trmt), 32'(0));
      checkOutput("rst_tx_data", 32'(tx_data), 32'(0));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_done", 32'(done), 32'(0));
      checkOutput("rst_cur_idx", 32'(cur_idx), 32'(0));
      checkOutput("rst_err", 32'(err), 32'(0));
      rst = 1'b0;
      tick();

      writeEntry(0, CMD_GO, 0);
      applyStimulus(1, 1'b0, 0, 1'b0);
      writeEntry(0, CMD_GO, 5);
      writeEntry(1, CMD_STOP, 0);
      applyStimulus(2, 1'b0, 0, 1'b0);
      applyStimulus(0, 1'b0, 0, 1'b0);
      applyStimulus(2, 1'b1, 5, 1'b0);

      // Abort beats start in IDLE: no done pulse even for an empty script, no playback.
      num_cmds = '0; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      checkOutput("abort_start_busy", 32'(busy), 32'(0));
      tick();
      checkOutput("abort_start_done", 32'(done), 32'(0));
      num_cmds = CNT_W'(2); start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      checkOutput("abort_start_busy2", 32'(busy), 32'(0));
      tick();
      checkOutput("abort_start_trmt", 32'(trmt), 32'(0));

      randomScript();
      applyStimulus(3, 1'b0, 0, 1'b1);
      applyStimulus(12, 1'b0, 0, 1'b0);

      for (int r = 0; r < 25; r++) begin
         if ($urandom_range(0, 2) == 0)
            randomScript();
         num = int'($urandom_range(0, 15));
         lp  = ($urandom_range(0, 3) == 0);
         if (lp)
            abort_after = int'($urandom_range(1, 10));
         else
            abort_after = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DEPTH)) : 0;
         applyStimulus(num, lp, abort_after, 1'($urandom_range(0, 1)));
      end

`ifdef CMD_SEQ_TIMEOUT_EN
      num_cmds = CNT_W'(1); loop_mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (51) tick();
      checkOutput("wd_pending_err", 32'(err), 32'(0));
      checkOutput("wd_pending_busy", 32'(busy), 32'(1));
      tick();
      checkOutput("wd_err", 32'(err), 32'(1));
      checkOutput("wd_busy", 32'(busy), 32'(0));
      checkOutput("wd_done", 32'(done), 32'(0));
      applyStimulus(1, 1'b0, 0, 1'b0);
`endif

      writeEntry(0, CMD_GO, 0);
      num_cmds = CNT_W'(DEPTH); loop_mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      checkOutput("mid_busy_before_rst", 32'(busy), 32'(1));
      rst = 1'b1;
      tick();
      checkOutput("mid_rst_trmt", 32'(trmt), 32'(0));
      checkOutput("mid_rst_tx_data", 32'(tx_data), 32'(0));
      checkOutput("mid_rst_busy", 32'(busy), 32'(0));
      checkOutput("mid_rst_done", 32'(done), 32'(0));
      checkOutput("mid_rst_cur_idx", 32'(cur_idx), 32'(0));
      rst = 1'b0;
      repeat (3) tick();
      checkOutput("post_rst_busy", 32'(busy), 32'(0));
      checkOutput("post_rst_trmt", 32'(trmt), 32'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
